// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-stage branch predictor: 2-bit counter
// encodings, the counter reset value and the sequential PC increment.
package branch_predictor_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [1:0] CTR_RESET = CTR_WNT;

  localparam int unsigned PC_INC = 4;

  // The MSB of a 2-bit counter is the taken/not-taken prediction.
  function automatic logic ctr_predicts_taken(input logic [1:0] cnt);
    return cnt[1];
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter; holds at
// strongly-taken / strongly-not-taken instead of wrapping.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_taken,
  output logic [1:0] o_cnt
);

  always_comb begin
    // NOTE: default assignment first so every path drives o_cnt and no latch is inferred.
    o_cnt = i_cnt;
    if (i_taken) begin
      if (i_cnt != CTR_ST) o_cnt = i_cnt + 2'd1;
    end else begin
      if (i_cnt != CTR_SNT) o_cnt = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: bimodal 2-bit BHT + direct-mapped BTB, trained
// from execute. Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history into the BHT index.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PC_WIDTH-1:0]  if_pc,
  output logic                 pred_taken,
  output logic [PC_WIDTH-1:0]  pred_target,
  output logic [PC_WIDTH-1:0]  next_pc,
  input  logic                 ex_valid,
  input  logic                 ex_is_branch,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic                 ex_taken,
  input  logic [PC_WIDTH-1:0]  ex_target,
  input  logic                 ex_pred_taken,
  input  logic [PC_WIDTH-1:0]  ex_pred_target,
  output logic                 mispredict,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 2;

  logic [1:0]          r_bht        [ENTRIES];
  logic [ENTRIES-1:0]  r_btb_valid;
  logic [TAG_W-1:0]    r_btb_tag    [ENTRIES];
  logic [PC_WIDTH-1:0] r_btb_target [ENTRIES];
  logic [CNT_WIDTH-1:0] r_branch_count;
  logic [CNT_WIDTH-1:0] r_mispredict_count;

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [INDEX_BITS-1:0] w_ex_idx;
  logic [INDEX_BITS-1:0] w_if_bht_idx;
  logic [INDEX_BITS-1:0] w_ex_bht_idx;
  logic [TAG_W-1:0]      w_if_tag;
  logic [TAG_W-1:0]      w_ex_tag;
  logic                  w_hit;
  logic                  w_br_resolve;
  logic                  w_btb_write;
  logic                  w_alias_clear;
  logic                  w_mispredict;
  logic [1:0]            w_ctr_next;

  assign w_if_idx = if_pc[INDEX_BITS+1:2];
  assign w_ex_idx = ex_pc[INDEX_BITS+1:2];
  assign w_if_tag = if_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign w_ex_tag = ex_pc[PC_WIDTH-1:INDEX_BITS+2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [INDEX_BITS-1:0] r_ghr;

  // History is only shifted at resolution, so fetch and execute see the same ghr.
  assign w_if_bht_idx = w_if_idx ^ r_ghr;
  assign w_ex_bht_idx = w_ex_idx ^ r_ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (w_br_resolve) begin
      r_ghr <= {r_ghr[INDEX_BITS-2:0], ex_taken};
    end
  end
`else
  assign w_if_bht_idx = w_if_idx;
  assign w_ex_bht_idx = w_ex_idx;
`endif

  // Fetch-side prediction reads pre-update table contents (no write bypass).
  assign w_hit       = r_btb_valid[w_if_idx] && (r_btb_tag[w_if_idx] == w_if_tag);
  assign pred_taken  = w_hit && ctr_predicts_taken(r_bht[w_if_bht_idx]);
  assign pred_target = r_btb_target[w_if_idx];
  assign next_pc     = pred_taken ? pred_target : if_pc + PC_WIDTH'(PC_INC);

  assign w_br_resolve  = ex_valid && ex_is_branch;
  assign w_btb_write   = w_br_resolve && ex_taken;
  assign w_alias_clear = ex_valid && !ex_is_branch && ex_pred_taken;

  always_comb begin
    w_mispredict = 1'b0;
    if (ex_valid) begin
      if (ex_is_branch) begin
        w_mispredict = (ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_pred_target != ex_target));
      end else begin
        // A non-branch predicted taken means the BTB entry aliased onto it.
        w_mispredict = ex_pred_taken;
      end
    end
  end

  assign mispredict  = w_mispredict;
  assign redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + PC_WIDTH'(PC_INC);

  sat_counter2 u_sat_counter2 (
    .i_cnt   (r_bht[w_ex_bht_idx]),
    .i_taken (ex_taken),
    .o_cnt   (w_ctr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= CTR_RESET;
    end else if (w_br_resolve) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_bht[w_ex_bht_idx] <= w_ctr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btb_valid <= '0;
    end else if (w_btb_write) begin
      r_btb_valid[w_ex_idx] <= 1'b1;
    end else if (w_alias_clear) begin
      r_btb_valid[w_ex_idx] <= 1'b0;
    end
  end

  // NOTE: tag/target payload is not reset; the valid bits alone make stale entries harmless.
  always_ff @(posedge clk) begin
    if (w_btb_write) begin
      r_btb_tag[w_ex_idx]    <= w_ex_tag;
      r_btb_target[w_ex_idx] <= ex_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_br_resolve && (r_branch_count != '1)) begin
        r_branch_count <= r_branch_count + CNT_WIDTH'(1);
      end
      if (w_mispredict && (r_mispredict_count != '1)) begin
        r_mispredict_count <= r_mispredict_count + CNT_WIDTH'(1);
      end
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default bimodal build).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] next_pc;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .PC_WIDTH   (32),
    .INDEX_BITS (6),
    .CNT_WIDTH  (32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .next_pc          (next_pc),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc, input logic exp_pt,
                       input logic [31:0] exp_next);
    @(negedge clk);
    ex_valid = 1'b0;
    if_pc    = pc;
    #1;
    check({tag, ".pred_taken"}, 32'(pred_taken), 32'(exp_pt));
    check({tag, ".next_pc"}, next_pc, exp_next);
  endtask

  task automatic resolve(input string tag, input logic is_br, input logic [31:0] pc,
                         input logic taken, input logic [31:0] tgt, input logic pt,
                         input logic [31:0] ptgt, input logic exp_mp,
                         input logic [31:0] exp_rd);
    @(negedge clk);
    ex_valid       = 1'b1;
    ex_is_branch   = is_br;
    ex_pc          = pc;
    ex_taken       = taken;
    ex_target      = tgt;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
    #1;
    check({tag, ".mispredict"}, 32'(mispredict), 32'(exp_mp));
    check({tag, ".redirect_pc"}, redirect_pc, exp_rd);
    @(posedge clk);
    #1 ex_valid = 1'b0;
  endtask

  task automatic counts(input string tag, input logic [31:0] exp_bc, input logic [31:0] exp_mc);
    check({tag, ".branch_count"}, branch_count, exp_bc);
    check({tag, ".mispredict_count"}, mispredict_count, exp_mc);
  endtask

  initial begin
    rst_n          = 1'b0;
    if_pc          = 32'h100;
    ex_valid       = 1'b0;
    ex_is_branch   = 1'b0;
    ex_pc          = '0;
    ex_taken       = 1'b0;
    ex_target      = '0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    fetch("reset", 32'h100, 1'b0, 32'h104);
    counts("reset", 0, 0);
    check("reset.mispredict", 32'(mispredict), 32'd0);

    // First taken branch: fetch in the same cycle still sees the old (empty) BTB.
    @(negedge clk);
    if_pc          = 32'h100;
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_pc          = 32'h100;
    ex_taken       = 1'b1;
    ex_target      = 32'h80;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
    #1;
    check("first.no_bypass", 32'(pred_taken), 32'd0);
    check("first.mispredict", 32'(mispredict), 32'd1);
    check("first.redirect_pc", redirect_pc, 32'h80);
    @(posedge clk);
    #1 ex_valid = 1'b0;

    fetch("btb_hit", 32'h100, 1'b1, 32'h80);
    check("btb_hit.pred_target", pred_target, 32'h80);
    counts("btb_hit", 1, 1);

    // Counter 10 -> 01 -> 00 -> 00 -> 00.
    resolve("nt1", 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    resolve("nt2", 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h80, 1'b0, 32'h104);
    resolve("nt3", 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h80, 1'b0, 32'h104);
    resolve("nt4", 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h80, 1'b0, 32'h104);
    counts("nt", 5, 2);
    fetch("sat_lo", 32'h100, 1'b0, 32'h104);

    // 00 -> 01 still predicts not-taken; 01 -> 10 predicts taken.
    resolve("t_from_snt", 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    counts("t_from_snt", 6, 3);
    fetch("wnt", 32'h100, 1'b0, 32'h104);
    resolve("t_from_wnt", 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    fetch("wt", 32'h100, 1'b1, 32'h80);

    // 10 -> 11 -> 11 -> 11, then one not-taken leaves 10 (no wrap at the top).
    for (int i = 0; i < 3; i++) begin
      resolve("t_correct", 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
    end
    resolve("nt_from_st", 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    counts("sat_hi", 11, 5);
    fetch("sat_hi", 32'h100, 1'b1, 32'h80);

    // Right direction, wrong target.
    resolve("tgt_change", 1'b1, 32'h100, 1'b1, 32'hC0, 1'b1, 32'h80, 1'b1, 32'hC0);
    counts("tgt_change", 12, 6);
    fetch("tgt_change", 32'h100, 1'b1, 32'hC0);

    // Non-branch predicted taken clears the BTB entry; not counted as a branch.
    resolve("alias_nb", 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'hC0, 1'b1, 32'h104);
    counts("alias_nb", 12, 7);
    fetch("alias_nb", 32'h100, 1'b0, 32'h104);
    resolve("plain_nb", 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104);
    counts("plain_nb", 12, 7);

    resolve("retrain", 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    fetch("retrain", 32'h100, 1'b1, 32'h80);

    // 0x200 shares index 0 with 0x100 but has a different tag.
    resolve("evict", 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h300);
    counts("evict", 14, 9);
    fetch("evicted", 32'h100, 1'b0, 32'h104);
    fetch("evictor", 32'h200, 1'b1, 32'h300);

    // ex_valid low: no mispredict, no training, no counting.
    @(negedge clk);
    ex_valid       = 1'b0;
    ex_is_branch   = 1'b1;
    ex_pc          = 32'h200;
    ex_taken       = 1'b1;
    ex_target      = 32'h900;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
    #1;
    check("invalid.mispredict", 32'(mispredict), 32'd0);
    @(posedge clk);
    fetch("invalid", 32'h200, 1'b1, 32'h300);
    counts("invalid", 14, 9);

    // Reset asserted while a taken-branch update is pending.
    @(negedge clk);
    if_pc          = 32'h200;
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_pc          = 32'h400;
    ex_taken       = 1'b1;
    ex_target      = 32'h500;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    counts("async_rst", 0, 0);
    check("async_rst.pred_taken", 32'(pred_taken), 32'd0);
    check("async_rst.next_pc", next_pc, 32'h204);
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    rst_n    = 1'b1;
    fetch("lost_update", 32'h400, 1'b0, 32'h404);
    counts("lost_update", 0, 0);

    resolve("post_rst", 1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h500);
    fetch("post_rst", 32'h400, 1'b1, 32'h500);
    counts("post_rst", 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-stage branch predictor. It is the consumer end of the execute-stage branch decision.
- Fetch side: predicts next PC from a 2-bit-counter BHT and a direct-mapped BTB.
- Execute side: takes the resolved outcome (taken flag, target, prediction carried down the pipe), trains the tables, and raises mispredict with a redirect PC.
- Also keeps branch and mispredict statistics counters.

Parameters:
PC_WIDTH, 32, PC/target width.
INDEX_BITS, 6, log2 table entries (64); index = pc[INDEX_BITS+1:2].
CNT_WIDTH, 32, statistics counter width.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
if_pc  in  PC_WIDTH  PC being fetched.
pred_taken  out  1  prediction for if_pc.
pred_target  out  PC_WIDTH  BTB target (valid only when pred_taken=1).
next_pc  out  PC_WIDTH  pred_taken ? pred_target : if_pc+4.
ex_valid  in  1  execute stage holds a live instruction.
ex_is_branch  in  1  instruction is a conditional branch.
ex_pc  in  PC_WIDTH  PC of execute instruction.
ex_taken  in  1  resolved branch decision from execute.
ex_target  in  PC_WIDTH  resolved branch target.
ex_pred_taken  in  1  prediction made at fetch, piped along.
ex_pred_target  in  PC_WIDTH  predicted target, piped along.
mispredict  out  1  flush younger stages and redirect fetch.
redirect_pc  out  PC_WIDTH  correct next PC when mispredict=1.
branch_count  out  CNT_WIDTH  resolved branches since reset.
mispredict_count  out  CNT_WIDTH  mispredicts since reset.

Behaviour:
Reset (rst_n low, asynchronous):
- All BHT counters = 2'b01 (weakly not-taken); all BTB valid = 0.
- branch_count = mispredict_count = 0.
- Fetch outputs therefore resolve to pred_taken=0, next_pc=if_pc+4.
- Reset mid-update discards the update.

Tag and hit:
- tag = pc[PC_WIDTH-1:INDEX_BITS+2].
- hit = valid[idx] && tag match.

Prediction (combinational, same cycle):
- pred_taken = hit && bht[idx][1]; pred_target = btb_target[idx].

Resolution (combinational from ex_* inputs; qualified by ex_valid):
- Branch case (ex_is_branch=1): mispredict = (ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target).
- Non-branch case (ex_is_branch=0): mispredict = ex_pred_taken (BTB alias).
- redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc+4.
- ex_valid=0: mispredict=0; no state change.

Training (rising edge, ex_valid=1):
- Branch: counter saturates at 2'b11 on taken, 2'b00 on not-taken; no wrap.
- Taken branch: BTB entry written (valid=1, tag, ex_target); this replaces any conflicting entry.
- Not-taken branch: BTB unchanged.
- Non-branch predicted taken: BTB valid[idx] cleared; BHT unchanged.

Same-index read and write in one cycle: prediction uses the pre-update value; no bypass.

Statistics:
- branch_count increments on each resolved branch; mispredict_count on each mispredict.
- Both saturate at all-ones.

Optional Feature:
BRANCH_PREDICTOR_GSHARE_EN
- Defined: adds an INDEX_BITS global history register, reset 0.
- BHT index = pc index XOR ghr; BTB still uses the plain pc index.
- ghr shifts in ex_taken on each resolved branch (non-speculative).
- Undefined: bimodal BHT indexed by pc only; no ghr.

Decomposition:
- Shared package: weakly-not-taken reset constant, counter encodings (SNT=00, WNT=01, WT=10, ST=11), PC+4 increment constant.
- One natural sub-module: sat_counter2 (2-bit saturating counter next-state function), reused per BHT update.

Test Plan:
- Reset, if_pc=0x100 → pred_taken=0, next_pc=0x104; both counters 0.
- Resolve taken branch ex_pc=0x100, target 0x80, pred_taken=0 → mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 → pred_taken=1, next_pc=0x80.
- Four not-taken resolutions at 0x100 → counter saturates 00. Then one taken → 01, pred_taken stays 0.
- Non-branch at 0x100 with ex_pred_taken=1 → mispredict=1, redirect_pc=0x104. Next cycle BTB miss at 0x100.
- Alias: taken branch at 0x200 (same index, different tag) evicts 0x100 entry → fetch 0x100 predicts not-taken. Target change 0x80→0xC0 with pred_taken=1 → mispredict, redirect 0xC0.
- Assert rst_n low mid-sequence with ex_valid=1 → tables and counters cleared immediately, update lost.
